// File: rtl/accel_packet_pkg.sv
// Shared definitions for the accelerometer UDP payload packetizer.
package accel_packet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    SAMPLE,
    WAIT_SAMPLE
  } state_e;

  localparam int unsigned HEADER_BYTES  = 5;
  localparam int unsigned SAMPLE_BYTES  = 6;
  localparam logic [15:0] DEFAULT_MAGIC = 16'hA5C3;

endpackage

// File: rtl/axis_interface.sv
// Minimal AXI-Stream bundle with source/sink views.
interface axis_interface #(
  parameter int DATA_WIDTH = 8
) ();

  localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tuser;

  modport Source (output tdata, tvalid, tlast, tkeep, tuser, input tready);
  modport Sink   (input tdata, tvalid, tlast, tkeep, tuser, output tready);

endinterface

// File: rtl/accel_udp_packetizer.sv
// Packs 48-bit ADXL345 samples into a byte-wide UDP payload stream:
// 5-byte header (magic, sequence number, sample count) then 6 bytes per sample.
module accel_udp_packetizer
  import accel_packet_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_PACKET = 8,
  parameter logic [15:0] MAGIC              = DEFAULT_MAGIC
) (
  input  logic          clk,
  input  logic          reset,
  axis_interface.Sink   sample_stream,
  axis_interface.Source payload_stream,
  output logic          busy,
  output logic [15:0]   seq_num
);

  localparam logic [7:0] SPP      = 8'(SAMPLES_PER_PACKET);
  localparam logic [2:0] LAST_HDR = 3'(HEADER_BYTES - 1);
  localparam logic [2:0] LAST_SMP = 3'(SAMPLE_BYTES - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [47:0] hold_q, hold_d;
  logic [15:0] seq_q, seq_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tlast_q, s_tready_q, busy_q;
  logic        s_fire, p_fire;
  logic        unused_sink_sideband;

  assign s_fire = sample_stream.tvalid && s_tready_q;
  assign p_fire = tvalid_q && payload_stream.tready;

  // Sample-side sideband carries no information for this packet format.
  assign unused_sink_sideband = ^{sample_stream.tlast, sample_stream.tkeep, sample_stream.tuser};

  // Next-state: advance byte index only on an accepted byte, capture samples on acceptance
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    seq_d   = seq_q;
    case (state_q)
      IDLE: begin
        if (s_fire) begin
          hold_d  = sample_stream.tdata;
          cnt_d   = 8'd1;
          idx_d   = '0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (p_fire) begin
          if (idx_q == LAST_HDR) begin
            idx_d   = '0;
            state_d = SAMPLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      SAMPLE: begin
        if (p_fire) begin
          if (idx_q == LAST_SMP) begin
            idx_d = '0;
            if (cnt_q == SPP) begin
              state_d = IDLE;
              seq_d   = seq_q + 16'd1;
            end else begin
              state_d = WAIT_SAMPLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      WAIT_SAMPLE: begin
        if (s_fire) begin
          hold_d  = sample_stream.tdata;
          cnt_d   = cnt_q + 8'd1;
          idx_d   = '0;
          state_d = SAMPLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte mux for the byte that will be presented after this edge
  always_comb begin
    tdata_d = '0;
    if (state_d == HEADER) begin
      case (idx_d)
        3'd0:    tdata_d = MAGIC[15:8];
        3'd1:    tdata_d = MAGIC[7:0];
        3'd2:    tdata_d = seq_d[15:8];
        3'd3:    tdata_d = seq_d[7:0];
        default: tdata_d = SPP;
      endcase
    end else if (state_d == SAMPLE) begin
      case (idx_d)
        3'd0:    tdata_d = hold_d[7:0];
        3'd1:    tdata_d = hold_d[15:8];
        3'd2:    tdata_d = hold_d[23:16];
        3'd3:    tdata_d = hold_d[31:24];
        3'd4:    tdata_d = hold_d[39:32];
        default: tdata_d = hold_d[47:40];
      endcase
    end
  end

  // State and stream outputs registered together; outputs are decoded from the
  // next state so they line up with it and stay frozen while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      seq_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      s_tready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      seq_q      <= seq_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= (state_d == HEADER) || (state_d == SAMPLE);
      tlast_q    <= (state_d == SAMPLE) && (idx_d == LAST_SMP) && (cnt_d == SPP);
      s_tready_q <= (state_d == IDLE) || (state_d == WAIT_SAMPLE);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign payload_stream.tvalid = tvalid_q;
  assign payload_stream.tdata  = tdata_q;
  assign payload_stream.tlast  = tlast_q;
  assign payload_stream.tkeep  = '1;
  assign payload_stream.tuser  = 1'b0;
  assign sample_stream.tready  = s_tready_q;
  assign busy                  = busy_q;
  assign seq_num               = seq_q;

endmodule

// File: tb/tb_accel_udp_packetizer.sv
// Bench for accel_udp_packetizer: two instances (8 and 1 samples per packet),
// packets predicted from the byte-layout rules and compared byte for byte.
module tb_accel_udp_packetizer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axis_interface #(.DATA_WIDTH(48)) s8 ();
  axis_interface #(.DATA_WIDTH(48)) s1 ();
  axis_interface #(.DATA_WIDTH(8))  p8 ();
  axis_interface #(.DATA_WIDTH(8))  p1 ();

  logic [1:0]  busy, svld, prdy, sr, pv, pl, pk, pu;
  logic [15:0] seqn [2];
  logic [47:0] sdat [2];
  logic [7:0]  pd   [2];

  assign s8.tvalid = svld[0];
  assign s8.tdata  = sdat[0];
  assign s8.tlast  = 1'b1;
  assign s8.tkeep  = '1;
  assign s8.tuser  = 1'b1;
  assign s1.tvalid = svld[1];
  assign s1.tdata  = sdat[1];
  assign s1.tlast  = 1'b1;
  assign s1.tkeep  = '0;
  assign s1.tuser  = 1'b1;
  assign p8.tready = prdy[0];
  assign p1.tready = prdy[1];
  assign sr    = {s1.tready, s8.tready};
  assign pv    = {p1.tvalid, p8.tvalid};
  assign pl    = {p1.tlast, p8.tlast};
  assign pk    = {p1.tkeep, p8.tkeep};
  assign pu    = {p1.tuser, p8.tuser};
  assign pd[0] = p8.tdata;
  assign pd[1] = p1.tdata;

  accel_udp_packetizer #(.SAMPLES_PER_PACKET(8)) dut8 (
    .clk(clk), .reset(reset), .sample_stream(s8), .payload_stream(p8),
    .busy(busy[0]), .seq_num(seqn[0])
  );

  accel_udp_packetizer #(.SAMPLES_PER_PACKET(1), .MAGIC(16'hA5C3)) dut1 (
    .clk(clk), .reset(reset), .sample_stream(s1), .payload_stream(p1),
    .busy(busy[1]), .seq_num(seqn[1])
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned rdy    [2];
  logic [47:0] sq     [2][$];
  logic [8:0]  outq   [2][$];
  logic [8:0]  expq   [2][$];
  int          gapq   [2][$];
  int          bsince [2];
  int          nlast  [2];
  logic [15:0] mseq   [2];
  bit          sacc   [2];
  bit          inpkt  [2];
  bit          prev_st[2];
  logic [8:0]  prev_b [2];
  int          edges = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) edges <= 0;
    else       edges <= edges + 1;

  // Source/sink drivers: update #1 after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (sacc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
      sacc[i] = 1'b0;
      svld[i] = (sq[i].size() > 0);
      sdat[i] = (sq[i].size() > 0) ? sq[i][0] : '0;
      prdy[i] = ($urandom_range(0, 99) < rdy[i]);
    end
  end

  // Monitor on the falling edge: predicts the handshakes of the next rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        sacc[i]    = 1'b0;
        inpkt[i]   = 1'b0;
        prev_st[i] = 1'b0;
      end else begin
        if (edges > 0) begin
          chk("busy", 64'(busy[i]), 64'(inpkt[i]));
          chk("sample_ready_vs_valid", 64'(sr[i]), 64'(!pv[i]));
          if (prev_st[i])
            chk("stall_hold", 64'({pv[i], pl[i], pd[i]}), 64'({1'b1, prev_b[i]}));
          if (pv[i]) chk("keep_user", 64'({pk[i], pu[i]}), 64'(2'b10));
        end
        sacc[i] = svld[i] && sr[i];
        if (sacc[i]) begin
          gapq[i].push_back(bsince[i]);
          bsince[i] = 0;
          inpkt[i]  = 1'b1;
        end
        if (pv[i] && prdy[i]) begin
          outq[i].push_back({pl[i], pd[i]});
          bsince[i]++;
          if (pl[i]) begin
            nlast[i]++;
            inpkt[i] = 1'b0;
          end
        end
        prev_st[i] = pv[i] && !prdy[i];
        prev_b[i]  = {pl[i], pd[i]};
      end
    end
  end

  // Reference: builds the expected packet from the layout rules and queues its samples.
  task automatic send_pkt(input int i, input bit rnd, input logic [47:0] fixed);
    int          n;
    logic [47:0] v;
    logic [7:0]  hdr [5];
    n   = (i == 0) ? 8 : 1;
    hdr = '{8'hA5, 8'hC3, mseq[i][15:8], mseq[i][7:0], 8'(n)};
    for (int k = 0; k < 5; k++) expq[i].push_back({1'b0, hdr[k]});
    for (int s = 0; s < n; s++) begin
      v = rnd ? {16'($urandom), 32'($urandom)} : fixed;
      sq[i].push_back(v);
      for (int b = 0; b < 6; b++) expq[i].push_back({(s == n - 1) && (b == 5), v[8*b +: 8]});
    end
    mseq[i] = mseq[i] + 16'd1;
  endtask

  task automatic wait_pkts(input int i, input int n);
    int c;
    c = 0;
    while (nlast[i] < n && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk("packet_timeout", 64'(nlast[i] >= n), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare(input int i, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < expq[i].size(); k++)
      if (k >= outq[i].size() || outq[i][k] !== expq[i][k]) begin
        if (bad == 0) $display("  %s: first differing byte index %0d", tag, k);
        bad++;
      end
    chk({tag, "_len"}, 64'(outq[i].size()), 64'(expq[i].size()));
    chk({tag, "_bytes"}, 64'(bad), 64'd0);
    outq[i].delete();
    expq[i].delete();
    nlast[i] = 0;
  endtask

  typedef struct {
    int          dut;
    bit          rnd;
    logic [47:0] smp;
    int unsigned rdy;
    int          npkts;
    int          exp_len;
    logic [15:0] exp_seq;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int   d, c, bad6;

    svld = '0;
    prdy = '0;
    for (int i = 0; i < 2; i++) begin
      sdat[i] = '0; rdy[i] = 100; mseq[i] = '0; nlast[i] = 0; bsince[i] = 0;
      sacc[i] = 1'b0; inpkt[i] = 1'b0; prev_st[i] = 1'b0; prev_b[i] = '0;
    end

    tbl[0] = '{dut:0, rnd:1'b0, smp:48'h0605_0403_0201, rdy:100, npkts:1, exp_len:53, exp_seq:16'd1};
    tbl[1] = '{dut:0, rnd:1'b1, smp:48'h0,              rdy:50,  npkts:3, exp_len:53, exp_seq:16'd4};
    tbl[2] = '{dut:1, rnd:1'b0, smp:48'h0605_0403_0201, rdy:100, npkts:1, exp_len:11, exp_seq:16'd1};
    tbl[3] = '{dut:1, rnd:1'b1, smp:48'h0,              rdy:50,  npkts:4, exp_len:11, exp_seq:16'd5};
    tbl[4] = '{dut:0, rnd:1'b1, smp:48'h0,              rdy:70,  npkts:2, exp_len:53, exp_seq:16'd6};

    // Reset values, and sample tready held low until the first edge after release
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_tvalid", 64'(pv[k]), 64'd0);
      chk("rst_tlast",  64'(pl[k]), 64'd0);
      chk("rst_tdata",  64'(pd[k]), 64'd0);
      chk("rst_tready", 64'(sr[k]), 64'd0);
      chk("rst_busy",   64'(busy[k]), 64'd0);
      chk("rst_seq",    64'(seqn[k]), 64'd0);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("tready_before_edge", 64'(sr), 64'd0);
    @(negedge clk);
    chk("tready_after_edge", 64'(sr), 64'(2'b11));

    // Table-driven packet runs
    for (int r = 0; r < 5; r++) begin
      d      = tbl[r].dut;
      rdy[d] = tbl[r].rdy;
      for (int p = 0; p < tbl[r].npkts; p++) send_pkt(d, tbl[r].rnd, tbl[r].smp);
      wait_pkts(d, tbl[r].npkts);
      chk("row_len", 64'(outq[d].size()), 64'(tbl[r].npkts * tbl[r].exp_len));
      compare(d, "row");
      chk("row_seq", 64'(seqn[d]), 64'(tbl[r].exp_seq));
      chk("row_idle", 64'(busy[d]), 64'd0);
      rdy[d] = 100;
    end

    // Sample backpressure: bytes accepted between consecutive sample acceptances
    gapq[0].delete();
    bsince[0] = 0;
    rdy[0] = 50;
    send_pkt(0, 1'b1, 48'h0);
    wait_pkts(0, 1);
    chk("gap_count", 64'(gapq[0].size()), 64'd8);
    chk("gap_header", 64'(gapq[0].size() > 1 ? gapq[0][1] : -1), 64'd11);
    bad6 = 0;
    for (int k = 2; k < gapq[0].size(); k++) if (gapq[0][k] != 6) bad6++;
    chk("gap_sample", 64'(bad6), 64'd0);
    compare(0, "gap");
    rdy[0] = 100;

    // Sequence number wrap
    @(negedge clk);
    force dut8.seq_q = 16'hFFFF;
    @(posedge clk);
    #1 release dut8.seq_q;
    mseq[0] = 16'hFFFF;
    @(negedge clk);
    chk("seq_preload", 64'(seqn[0]), 64'hFFFF);
    send_pkt(0, 1'b1, 48'h0);
    send_pkt(0, 1'b1, 48'h0);
    wait_pkts(0, 2);
    compare(0, "wrap");
    chk("seq_after_wrap", 64'(seqn[0]), 64'd1);

    // Reset mid-packet after byte 20
    send_pkt(0, 1'b1, 48'h0);
    c = 0;
    while (outq[0].size() < 20 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("reach_byte20", 64'(outq[0].size() >= 20), 64'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_tvalid", 64'(pv[0]), 64'd0);
    chk("midrst_tlast",  64'(pl[0]), 64'd0);
    chk("midrst_busy",   64'(busy[0]), 64'd0);
    chk("midrst_seq",    64'(seqn[0]), 64'd0);
    chk("abandon_no_tlast", 64'(nlast[0]), 64'd0);
    for (int i = 0; i < 2; i++) begin
      sq[i].delete(); outq[i].delete(); expq[i].delete(); gapq[i].delete();
      nlast[i] = 0; mseq[i] = '0;
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    send_pkt(0, 1'b1, 48'h0);
    send_pkt(1, 1'b0, 48'hFEDC_BA98_7654);
    wait_pkts(0, 1);
    wait_pkts(1, 1);
    chk("post_rst_head", 64'({outq[0].size() > 3 ? outq[0][0][7:0] : 8'h0,
                              outq[0].size() > 3 ? outq[0][1][7:0] : 8'h0,
                              outq[0].size() > 3 ? outq[0][2][7:0] : 8'h0,
                              outq[0].size() > 3 ? outq[0][3][7:0] : 8'h0}), 64'hA5C3_0000);
    compare(0, "post_rst8");
    compare(1, "post_rst1");
    chk("post_rst_seq", 64'({seqn[0], seqn[1]}), 64'h0001_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
